// File: rtl/gan_layer_sequencer_pkg.sv
// Shared definitions for the GAN layer sequencer: state encoding,
// default sizing and the layer index type.
package gan_layer_sequencer_pkg;

    localparam int unsigned DEFAULT_NUM_LAYERS     = 3;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 65536;
    localparam int unsigned LAYER_IDX_W            = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_ERROR  = 3'd4
    } seq_state_e;

    typedef logic [LAYER_IDX_W-1:0] layer_idx_t;

endpackage

// File: rtl/gan_layer_sequencer_watchdog.sv
// Per-layer watchdog: counts cycles while enabled and raises a registered
// expired flag once the count sits at TIMEOUT_CYCLES-1.
module seq_watchdog
    import gan_layer_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned TO_WIDTH       = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_WIDTH-1:0] LIMIT = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TO_WIDTH-1:0] count_q, count_d;
    logic                expired_q, expired_d;

    // The count saturates at LIMIT so a stalled enable cannot wrap it back
    // below the threshold.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
        expired_d = !clear && (count_d == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/gan_layer_sequencer.sv
// Control-only scheduler that starts each generator layer in turn for one
// latent vector and hands the finished frame downstream.
module gan_layer_sequencer
    import gan_layer_sequencer_pkg::*;
#(
    parameter int unsigned NUM_LAYERS     = DEFAULT_NUM_LAYERS,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned TO_WIDTH       = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  clear_err,
    output logic                  busy,
    output logic [2:0]            cur_layer,
    output logic                  error,
    output logic [2:0]            err_layer,
    output logic [15:0]           frames_done
);

    localparam layer_idx_t LAST_LAYER = layer_idx_t'(NUM_LAYERS - 1);

    seq_state_e            state_q, state_d;
    layer_idx_t            cur_layer_q, cur_layer_d;
    layer_idx_t            err_layer_q, err_layer_d;
    logic [NUM_LAYERS-1:0] layer_start_q, layer_start_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  error_q, error_d;
    logic [15:0]           frames_done_q, frames_done_d;
    logic                  cur_done;
    logic                  expired;

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_WIDTH      (TO_WIDTH)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_d == ST_START),
        .enable (state_d == ST_WAIT),
        .expired(expired)
    );

    // Only the done bit of the layer being awaited matters.
    always_comb begin
        cur_done = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (cur_layer_q == layer_idx_t'(i)) begin
                cur_done = layer_done[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cur_layer_q   <= '0;
            err_layer_q   <= '0;
            layer_start_q <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
            frames_done_q <= '0;
        end else begin
            state_q       <= state_d;
            cur_layer_q   <= cur_layer_d;
            err_layer_q   <= err_layer_d;
            layer_start_q <= layer_start_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
            frames_done_q <= frames_done_d;
        end
    end

    // A done arriving on the watchdog's final cycle still advances.
    always_comb begin
        state_d     = state_q;
        cur_layer_d = cur_layer_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d     = ST_START;
                    cur_layer_d = '0;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (cur_done) begin
                    if (cur_layer_q == LAST_LAYER) begin
                        state_d = ST_OUTPUT;
                    end else begin
                        state_d     = ST_START;
                        cur_layer_d = cur_layer_q + 1'b1;
                    end
                end else if (expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (clear_err) begin
                    state_d     = ST_IDLE;
                    cur_layer_d = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cur_layer_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        out_valid_d = (state_d == ST_OUTPUT);
        error_d     = (state_d == ST_ERROR);
        for (int i = 0; i < NUM_LAYERS; i++) begin
            layer_start_d[i] = (state_d == ST_START) && (cur_layer_d == layer_idx_t'(i));
        end
        err_layer_d = err_layer_q;
        if ((state_q == ST_WAIT) && (state_d == ST_ERROR)) begin
            err_layer_d = cur_layer_q;
        end
        frames_done_d = frames_done_q;
        if ((state_q == ST_OUTPUT) && out_ready) begin
            frames_done_d = frames_done_q + 16'd1;
        end
    end

    assign in_ready    = in_ready_q;
    assign layer_start = layer_start_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign cur_layer   = cur_layer_q;
    assign error       = error_q;
    assign err_layer   = err_layer_q;
    assign frames_done = frames_done_q;

endmodule
